// File: rtl/crc_ctrl_pkg.sv
// Shared types and helpers for the serial CRC frame sequencer.
package crc_ctrl_pkg;

   localparam int unsigned DefDataWd  = 8;
   localparam int unsigned DefLfsrWd  = 8;
   localparam int unsigned DefTimeout = 16;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StShift,
      StWaitValid,
      StCollect,
      StHold
   } ctrl_state_e;

   // Ceiling log2, never below 1 so every counter has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) result++;
      if (result == 0) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/crc_sipo_capture.sv
// Serial-in/parallel-out collector for the engine's LSB-first CRC stream.
module crc_sipo_capture
   import crc_ctrl_pkg::*;
#(
   parameter int unsigned LFSR_WD = DefLfsrWd
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               shift,
   input  logic               bit_in,
   output logic [LFSR_WD-1:0] data,
   output logic               done
);

   localparam int unsigned IdxW = clog2(LFSR_WD);

   logic [IdxW-1:0]    idx_q;
   logic [LFSR_WD-1:0] data_q;

   // Asserted while the final bit position is being captured.
   assign done = (idx_q == IdxW'(LFSR_WD - 1));
   assign data = data_q;

   // Start writes bit 0; each shift writes the next position, index saturates at the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         data_q <= '0;
      end else if (start) begin
         data_q[0] <= bit_in;
         idx_q     <= IdxW'(1);
      end else if (shift) begin
         data_q[idx_q] <= bit_in;
         if (!done) idx_q <= idx_q + 1'b1;
      end
   end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer: accepts words, reseeds and feeds the serial CRC engine,
// collects its serial CRC and holds it until the consumer takes it.
module crc_frame_ctrl
   import crc_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WD = DefDataWd,
   parameter int unsigned LFSR_WD = DefLfsrWd,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [DATA_WD-1:0] IN_DATA,
   input  logic               IN_LAST,
   input  logic               IN_VALID,
   output logic               IN_READY,
   output logic               ENG_INIT,
   output logic               ENG_DATA,
   output logic               ENG_ACTIVE,
   input  logic               ENG_CRC,
   input  logic               ENG_VALID,
   output logic [LFSR_WD-1:0] CRC_OUT,
   output logic               CRC_VALID,
   input  logic               CRC_READY,
   output logic               ERR_UNDERRUN,
   output logic               ERR_TIMEOUT
);

   localparam int unsigned BitW = clog2(DATA_WD);
   localparam int unsigned ToW  = clog2(TIMEOUT + 1);

   ctrl_state_e        state_q, state_d;
   logic [DATA_WD-1:0] sreg_q, sreg_d;
   logic               last_q, last_d;
   logic [BitW-1:0]    bcnt_q, bcnt_d;
   logic [ToW-1:0]     tcnt_q, tcnt_d;
   logic               eng_init_d, crc_valid_d, err_underrun_d, err_timeout_d;
   logic               cap_start, cap_shift, cap_done;
   logic               word_end;

   assign word_end = (bcnt_q == BitW'(DATA_WD - 1));

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_d        = state_q;
      sreg_d         = sreg_q;
      last_d         = last_q;
      bcnt_d         = bcnt_q;
      tcnt_d         = tcnt_q;
      eng_init_d     = 1'b0;
      err_underrun_d = 1'b0;
      err_timeout_d  = 1'b0;
      cap_start      = 1'b0;
      cap_shift      = 1'b0;
      IN_READY       = 1'b0;
      ENG_ACTIVE     = 1'b0;
      ENG_DATA       = 1'b0;
      unique case (state_q)
         StIdle: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               sreg_d  = IN_DATA;
               last_d  = IN_LAST;
               state_d = StInit;
            end
         end
         StInit: begin
            bcnt_d  = '0;
            state_d = StShift;
         end
         StShift: begin
            ENG_ACTIVE = 1'b1;
            ENG_DATA   = sreg_q[0];
            sreg_d     = sreg_q >> 1;
            if (!word_end) begin
               bcnt_d = bcnt_q + 1'b1;
            end else if (last_q) begin
               tcnt_d  = '0;
               state_d = StWaitValid;
            end else begin
               // Word boundary: reload without a gap, or drop the frame.
               IN_READY = 1'b1;
               if (IN_VALID) begin
                  sreg_d = IN_DATA;
                  last_d = IN_LAST;
                  bcnt_d = '0;
               end else begin
                  err_underrun_d = 1'b1;
                  eng_init_d     = 1'b1;
                  state_d        = StIdle;
               end
            end
         end
         StWaitValid: begin
            if (ENG_VALID) begin
               cap_start = 1'b1;
               state_d   = StCollect;
            end else begin
               if (tcnt_q != ToW'(TIMEOUT)) tcnt_d = tcnt_q + 1'b1;
               if (tcnt_d == ToW'(TIMEOUT)) begin
                  err_timeout_d = 1'b1;
                  state_d       = StIdle;
               end
            end
         end
         StCollect: begin
            // ENG_VALID is deliberately not consulted once collection has started.
            cap_shift = 1'b1;
            if (cap_done) state_d = StHold;
         end
         StHold: begin
            if (CRC_READY) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StInit) eng_init_d = 1'b1;
      crc_valid_d = (state_d == StHold);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StIdle;
         sreg_q       <= '0;
         last_q       <= 1'b0;
         bcnt_q       <= '0;
         tcnt_q       <= '0;
         ENG_INIT     <= 1'b1;
         CRC_VALID    <= 1'b0;
         ERR_UNDERRUN <= 1'b0;
         ERR_TIMEOUT  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         last_q       <= last_d;
         bcnt_q       <= bcnt_d;
         tcnt_q       <= tcnt_d;
         ENG_INIT     <= eng_init_d;
         CRC_VALID    <= crc_valid_d;
         ERR_UNDERRUN <= err_underrun_d;
         ERR_TIMEOUT  <= err_timeout_d;
      end
   end

   crc_sipo_capture #(
      .LFSR_WD (LFSR_WD)
   ) u_capture (
      .clk    (CLK),
      .rst    (RST),
      .start  (cap_start),
      .shift  (cap_shift),
      .bit_in (ENG_CRC),
      .data   (CRC_OUT),
      .done   (cap_done)
   );

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Randomized bench for crc_frame_ctrl with a stub engine and a cycle-timeline model.
module tb_crc_frame_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] IN_DATA;
   logic       IN_LAST, IN_VALID, IN_READY;
   logic       ENG_INIT, ENG_DATA, ENG_ACTIVE, ENG_CRC, ENG_VALID;
   logic [7:0] CRC_OUT;
   logic       CRC_VALID, CRC_READY, ERR_UNDERRUN, ERR_TIMEOUT;

   crc_frame_ctrl #(
      .DATA_WD (8),
      .LFSR_WD (8),
      .TIMEOUT (16)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .IN_DATA      (IN_DATA),
      .IN_LAST      (IN_LAST),
      .IN_VALID     (IN_VALID),
      .IN_READY     (IN_READY),
      .ENG_INIT     (ENG_INIT),
      .ENG_DATA     (ENG_DATA),
      .ENG_ACTIVE   (ENG_ACTIVE),
      .ENG_CRC      (ENG_CRC),
      .ENG_VALID    (ENG_VALID),
      .CRC_OUT      (CRC_OUT),
      .CRC_VALID    (CRC_VALID),
      .CRC_READY    (CRC_READY),
      .ERR_UNDERRUN (ERR_UNDERRUN),
      .ERR_TIMEOUT  (ERR_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;
   int frame_no = 0;

   // Frame description; cycle 0 is the accept cycle.
   logic [7:0] words [4];
   logic [7:0] crc_val;
   int n_words, under_k, eng_d, rdy_r;
   int fw, w_c, v_c, h_c, idle_from;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // nw words, underrun after word uk (-1: none), engine delay ed (-1: never), ready delay rr.
   function automatic void setup_frame(input int nw, input int uk, input int ed,
                                       input logic [7:0] cv, input int rr);
      n_words = nw; under_k = uk; eng_d = ed; crc_val = cv; rdy_r = rr;
      fw  = (uk >= 0) ? uk + 1 : nw;
      w_c = 2 + fw * 8;
      v_c = w_c + ed;
      h_c = v_c + 8;
      if (uk >= 0)      idle_from = 2 + fw * 8;
      else if (ed < 0)  idle_from = w_c + 16;
      else              idle_from = h_c + rr + 1;
   endfunction

   // Expected {IN_READY, ENG_INIT, ENG_ACTIVE, ENG_DATA, CRC_VALID, ERR_U, ERR_T, CRC_OUT}.
   function automatic logic [14:0] exp_at(input int c);
      logic rdy, init, act, dat, cv, eu, et;
      logic [7:0] co;
      rdy = 0; init = 0; act = 0; dat = 0; cv = 0; eu = 0; et = 0; co = '0;
      if (c == 0 || c >= idle_from) rdy = 1;
      if (c == 1) init = 1;
      if (c >= 2 && c <= 1 + fw * 8) begin
         act = 1;
         dat = words[(c - 2) / 8][(c - 2) % 8];
         if ((c - 2) % 8 == 7 && (c - 2) / 8 < n_words - 1) rdy = 1;
      end
      if (under_k >= 0 && c == idle_from) begin
         eu = 1;
         init = 1;
      end
      if (under_k < 0 && eng_d < 0 && c == idle_from) et = 1;
      if (under_k < 0 && eng_d >= 0 && c >= h_c && c <= h_c + rdy_r) begin
         cv = 1;
         co = crc_val;
      end
      return {rdy, init, act, dat, cv, eu, et, co};
   endfunction

   function automatic logic [14:0] raw_vec();
      return {IN_READY, ENG_INIT, ENG_ACTIVE, ENG_DATA, CRC_VALID, ERR_UNDERRUN, ERR_TIMEOUT,
              CRC_OUT};
   endfunction

   // Data bit and CRC word are compared only where they are defined.
   function automatic logic [14:0] obs_vec(input logic [14:0] e);
      logic [14:0] o;
      o = raw_vec();
      if (!e[12]) o[11] = 1'b0;
      if (!e[10]) o[7:0] = '0;
      return o;
   endfunction

   task automatic drive_cycle(input int c);
      logic [14:0] e;
      int j;
      e = exp_at(c);
      IN_VALID = 1'b0;
      IN_DATA  = 8'($urandom);
      IN_LAST  = 1'($urandom);
      if (c == 0) begin
         IN_VALID = 1'b1;
         IN_DATA  = words[0];
         IN_LAST  = (n_words == 1);
      end else if (c >= 2 && c <= 1 + fw * 8 && (c - 2) % 8 == 7 && (c - 2) / 8 < fw - 1) begin
         j = (c - 2) / 8 + 1;
         IN_VALID = 1'b1;
         IN_DATA  = words[j];
         IN_LAST  = (j == n_words - 1);
      end else if (!e[14] && c < idle_from) begin
         IN_VALID = 1'($urandom);
      end
      // Stub engine: CRC bits LSB first; ENG_VALID may drop after the first bit.
      ENG_VALID = 1'b0;
      ENG_CRC   = 1'($urandom);
      if (under_k < 0 && eng_d >= 0 && c >= v_c && c < v_c + 8) begin
         ENG_CRC   = crc_val[c - v_c];
         ENG_VALID = (c == v_c) ? 1'b1 : 1'($urandom);
      end
      CRC_READY = 1'b0;
      if (under_k < 0 && eng_d >= 0 && c >= h_c) CRC_READY = (c == h_c + rdy_r);
      else if (c < idle_from) CRC_READY = 1'($urandom);
   endtask

   task automatic check_cycle(input int c);
      logic [14:0] e;
      e = exp_at(c);
      check_eq($sformatf("f%0d_c%0d", frame_no, c), 32'(obs_vec(e)), 32'(e));
   endtask

   task automatic run_frame();
      int act_seen = 0;
      int init_seen = 0;
      for (int c = 0; c <= idle_from + 1; c++) begin
         drive_cycle(c);
         check_cycle(c);
         act_seen  += int'(ENG_ACTIVE);
         init_seen += int'(ENG_INIT);
         @(posedge CLK); #1;
      end
      check_eq($sformatf("f%0d_active_cycles", frame_no), act_seen, fw * 8);
      check_eq($sformatf("f%0d_init_pulses", frame_no), init_seen, (under_k >= 0) ? 2 : 1);
      frame_no++;
   endtask

   task automatic idle_inputs();
      IN_VALID = 0; IN_DATA = '0; IN_LAST = 0; ENG_CRC = 0; ENG_VALID = 0; CRC_READY = 0;
   endtask

   initial begin
      int nw, uk, ed;
      RST = 1'b1;
      idle_inputs();
      repeat (2) @(posedge CLK);
      #1;
      check_eq("reset_state", 32'(raw_vec()), 32'(15'b110_0000_0000_0000));
      RST = 1'b0;
      @(posedge CLK); #1;
      check_eq("init_clears", 32'({ENG_INIT, IN_READY}), 32'(2'b01));

      // Single word A5, stub CRC 3C.
      words[0] = 8'hA5;
      setup_frame(1, -1, 3, 8'h3C, 4);
      run_frame();
      // Back-to-back three-word frame.
      words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
      setup_frame(3, -1, 0, 8'($urandom), 1);
      run_frame();
      // Underrun after the first of two words.
      words[0] = 8'h5A; words[1] = 8'hC3;
      setup_frame(2, 0, 0, 8'h00, 0);
      run_frame();
      // Engine never answers.
      words[0] = 8'h77;
      setup_frame(1, -1, -1, 8'h00, 0);
      run_frame();
      // Consumer stalls for 20 cycles.
      words[0] = 8'hE1;
      setup_frame(1, -1, 2, 8'h96, 20);
      run_frame();

      // Reset in the middle of shifting, then a clean frame.
      words[0] = 8'hA5;
      setup_frame(1, -1, 1, 8'h3C, 0);
      for (int c = 0; c < 6; c++) begin
         drive_cycle(c);
         check_cycle(c);
         @(posedge CLK); #1;
      end
      #2 RST = 1'b1;
      idle_inputs();
      #1;
      check_eq("async_reset", 32'(raw_vec()), 32'(15'b110_0000_0000_0000));
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      check_eq("post_reset_idle", 32'(raw_vec()), 32'(15'b100_0000_0000_0000));
      frame_no++;
      setup_frame(1, -1, 1, 8'h3C, 0);
      run_frame();

      // Randomized frames.
      for (int f = 0; f < 30; f++) begin
         nw = $urandom_range(1, 4);
         uk = -1;
         ed = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 12);
         if (nw >= 2 && $urandom_range(0, 4) == 0) uk = $urandom_range(0, nw - 2);
         for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
         setup_frame(nw, uk, ed, 8'($urandom), $urandom_range(0, 5));
         run_frame();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
